mul_arbiter: RTL and testbench

- Round-robin scheduler that shares one multi-cycle multiplier (`mul`: start/fin handshake, W-bit operands, RW-bit product) between NREQ requesters.
- Latches the winning requester's operands and pulses the multiplier's start.
- Waits for fin, returns the product on a shared result bus with a per-requester done pulse.
- A watchdog aborts a job if fin never arrives.
- Sits between client datapaths and the single `mul` instance.

---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/mul_arbiter_rr_pick.sv | 29 ++
 rtl/mul_arbiter.sv | 159 +++++++++++++++
 tb/tb_mul_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_arb_pkg : shared types/defaults for the multiplier arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mul_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } arb_state_e;

    localparam int RW_DEF      = 17;
    localparam int TIMEOUT_DEF = 64;

endpackage
`default_nettype wire

// File: rtl/mul_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin priority encoder                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id
);

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt_valid = 1'b1;
                gnt_id    = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_arbiter : round-robin sharing of one multi-cycle multiplier       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [RW-1:0]     res,
    output logic [W-1:0]      m_a,
    output logic [W-1:0]      m_b,
    output logic              m_start,
    input  logic [RW-1:0]     m_o,
    input  logic              m_fin
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [NREQ-1:0] c_one     = NREQ'(1);
    localparam logic [WDW-1:0]  c_wd_last = WDW'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [RW-1:0]   res_q, res_d;
    logic [W-1:0]    m_a_q, m_a_d;
    logic [W-1:0]    m_b_q, m_b_d;
    logic            m_start_q, m_start_d;

    logic            w_gnt_valid;
    logic [IDW-1:0]  w_gnt_id;
    logic [W-1:0]    w_a_arr [NREQ];
    logic [W-1:0]    w_b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = a_in[gi*W +: W];
        assign w_b_arr[gi] = b_in[gi*W +: W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        res_d     = res_q;
        m_a_d     = m_a_q;
        m_b_d     = m_b_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = '0;
        m_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (w_gnt_valid) begin
                    id_d      = w_gnt_id;
                    m_a_d     = w_a_arr[w_gnt_id];
                    m_b_d     = w_b_arr[w_gnt_id];
                    ack_d     = c_one << w_gnt_id;
                    m_start_d = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion arriving on the last watchdog cycle still wins.
                if (m_fin) begin
                    res_d   = m_o;
                    done_d  = c_one << id_q;
                    ptr_d   = id_q;
                    state_d = ST_DONE;
                end else if (wd_q == c_wd_last) begin
                    err_d   = c_one << id_q;
                    ptr_d   = id_q;
                    state_d = ST_ABORT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_DONE, ST_ABORT: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            ptr_q     <= IDW'(NREQ - 1);
            wd_q      <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            res_q     <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            m_start_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            res_q     <= res_d;
            m_a_q     <= m_a_d;
            m_b_q     <= m_b_d;
            m_start_q <= m_start_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign err     = err_q;
    assign res     = res_q;
    assign m_a     = m_a_q;
    assign m_b     = m_b_q;
    assign m_start = m_start_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mul_arbiter : scoreboard bench with a behavioural multiplier model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int RW      = 17;
    localparam int TIMEOUT = 64;

    logic              ck = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    logic [NREQ-1:0]   ack, done, err;
    logic [RW-1:0]     res;
    logic [W-1:0]      m_a, m_b;
    logic              m_start;
    logic [RW-1:0]     m_o = '0;
    logic              m_fin = 1'b0;

    always #5 ck = ~ck;

    mul_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .RW      (RW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .done    (done),
        .err     (err),
        .res     (res),
        .m_a     (m_a),
        .m_b     (m_b),
        .m_start (m_start),
        .m_o     (m_o),
        .m_fin   (m_fin)
    );

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } ack_t;

    typedef struct {
        bit          is_err;
        int          id;
        logic [RW-1:0] res;
        int          lat;
    } res_t;

    ack_t ack_q[$];
    res_t res_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    logic [RW-1:0] exp_res = '0;

    // Multiplier model: fin_at[k] raises m_fin k cycles after the start cycle.
    logic [127:0] fin_at = '0;
    bit           idle_fin = 1'b0;
    bit           m_act = 1'b0;
    int           m_k = 0;
    logic [RW-1:0] m_prod = '0;

    always @(posedge ck) cyc <= cyc + 1;

    always @(negedge ck) begin
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (m_start) begin
            m_act  = 1'b1;
            m_k    = 0;
            m_prod = {{(RW-W){1'b0}}, m_a} * {{(RW-W){1'b0}}, m_b};
        end else if (m_act) begin
            if (m_k == 127) m_act = 1'b0;
            else            m_k++;
        end
        m_fin = idle_fin || (m_act && fin_at[m_k]);
        m_o   = idle_fin ? 17'h1ABCD : m_prod;
    end

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    ack_t mon_a;
    res_t mon_r;
    always @(negedge ck) begin
        if (ack != '0 || m_start) begin
            if (ack_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ack: got ack=0x%0h m_start=%0b, expected none", ack, m_start);
            end else begin
                mon_a = ack_q.pop_front();
                chk("ack_id", 32'(ack), 32'(1) << mon_a.id);
                chk("m_start", 32'(m_start), 32'd1);
                chk("m_a", 32'(m_a), 32'(mon_a.a));
                chk("m_b", 32'(m_b), 32'(mon_a.b));
                last_ack_cyc = cyc;
            end
        end
        if (done != '0 || err != '0) begin
            if (res_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_result: got done=0x%0h err=0x%0h, expected none", done, err);
            end else begin
                mon_r = res_q.pop_front();
                chk("done", 32'(done), mon_r.is_err ? 32'd0 : (32'(1) << mon_r.id));
                chk("err", 32'(err), mon_r.is_err ? (32'(1) << mon_r.id) : 32'd0);
                chk("res", 32'(res), 32'(mon_r.res));
                if (mon_r.lat > 0) chk("latency", 32'(cyc - last_ack_cyc), 32'(mon_r.lat));
            end
        end
    end

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
    endtask

    task automatic push_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [RW-1:0] p, input int lat);
        ack_t t;
        res_t r;
        t.id = id; t.a = a; t.b = b;
        r.is_err = 1'b0; r.id = id; r.res = p; r.lat = lat;
        ack_q.push_back(t);
        res_q.push_back(r);
        exp_res = p;
        set_ops(id, a, b);
    endtask

    task automatic push_err(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        ack_t t;
        res_t r;
        t.id = id; t.a = a; t.b = b;
        r.is_err = 1'b1; r.id = id; r.res = exp_res; r.lat = lat;
        ack_q.push_back(t);
        res_q.push_back(r);
        set_ops(id, a, b);
    endtask

    // Requesters drop their line in their own ack cycle.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((ack_q.size() != 0 || res_q.size() != 0) && n < budget) begin
            @(negedge ck);
            req = req & ~ack;
            n++;
        end
        n_cmp++;
        if (ack_q.size() != 0 || res_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: got %0d acks / %0d results outstanding, expected 0",
                     tag, ack_q.size(), res_q.size());
            ack_q.delete();
            res_q.delete();
            req = '0;
        end
        repeat (2) @(negedge ck);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"},     32'(ack),     32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
        chk({tag, "_m_start"}, 32'(m_start), 32'd0);
        chk({tag, "_res"},     32'(res),     32'd0);
        chk({tag, "_m_a"},     32'(m_a),     32'd0);
        chk({tag, "_m_b"},     32'(m_b),     32'd0);
    endtask

    initial begin
        repeat (3) @(negedge ck);
        check_zero("reset");
        rst_n = 1'b1;
        fin_at = '0; fin_at[3] = 1'b1;

        // Single job, then a lone job on 3 to park the pointer at 3.
        push_job(0, 8'h0F, 8'h0F, 17'h000E1, 4); req[0] = 1'b1; drain("single", 200);
        push_job(3, 8'h12, 8'h34, 17'h003A8, 4); req[3] = 1'b1; drain("park", 200);

        // All four at once: served 0,1,2,3.
        push_job(0, 8'h02, 8'h03, 17'h00006, 4);
        push_job(1, 8'hFF, 8'hFF, 17'h0FE01, 4);
        push_job(2, 8'h00, 8'h55, 17'h00000, 4);
        push_job(3, 8'h80, 8'h02, 17'h00100, 4);
        req = 4'b1111; drain("simul", 400);

        // Fairness: after 2 completes, 3 beats 1.
        push_job(2, 8'h07, 8'h09, 17'h0003F, 4); req[2] = 1'b1; drain("fair2", 200);
        push_job(3, 8'h11, 8'h11, 17'h00121, 4);
        push_job(1, 8'h0A, 8'h0B, 17'h0006E, 4);
        req = 4'b1010; drain("fair31", 300);

        // Timeout: no fin ever, res must keep 0x6E.
        fin_at = '0;
        push_err(1, 8'h05, 8'h06, TIMEOUT + 1); req[1] = 1'b1; drain("timeout", 400);
        fin_at[3] = 1'b1;
        push_job(0, 8'h03, 8'h04, 17'h0000C, 4); req[0] = 1'b1; drain("after_abort", 200);

        // Spurious fin in IDLE with junk product.
        idle_fin = 1'b1;
        repeat (3) @(negedge ck);
        idle_fin = 1'b0;
        repeat (2) @(negedge ck);
        chk("res_idle_fin", 32'(res), 32'(exp_res));

        // Spurious fin in START, real one three cycles later.
        fin_at = '0; fin_at[0] = 1'b1; fin_at[3] = 1'b1;
        push_job(2, 8'h10, 8'h10, 17'h00100, 4); req[2] = 1'b1; drain("start_fin", 200);

        // Fin on the last watchdog cycle wins.
        fin_at = '0; fin_at[TIMEOUT] = 1'b1;
        push_job(3, 8'h21, 8'h03, 17'h00063, TIMEOUT + 1); req[3] = 1'b1; drain("race", 400);

        // Reset in the middle of WAIT.
        fin_at = '0;
        begin
            ack_t t;
            t.id = 0; t.a = 8'h09; t.b = 8'h09;
            ack_q.push_back(t);
        end
        set_ops(0, 8'h09, 8'h09);
        req[0] = 1'b1; drain("pre_reset", 200);
        repeat (3) @(negedge ck);
        rst_n = 1'b0;
        @(negedge ck);
        check_zero("midreset");
        rst_n = 1'b1;
        exp_res = '0;
        repeat (10) @(negedge ck);
        fin_at[3] = 1'b1;
        push_job(1, 8'h02, 8'h02, 17'h00004, 4);
        push_job(3, 8'h03, 8'h03, 17'h00009, 4);
        req = 4'b1010; drain("post_reset", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
